// File: rtl/display_scheduler_pkg.sv
// Shared types and constants for the display scheduler and its button debouncers.
package display_scheduler_pkg;

    typedef enum logic {
        SRC_DEBUG = 1'b0,
        SRC_CPU   = 1'b1
    } display_source_t;

    typedef enum logic {
        DEBUG    = 1'b0,
        CPU_HOLD = 1'b1
    } sched_state_t;

    localparam int unsigned NUM_DEBUG_REGS = 5;

    localparam logic [2:0] REG_A = 3'd0;
    localparam logic [2:0] REG_B = 3'd1;
    localparam logic [2:0] REG_C = 3'd2;
    localparam logic [2:0] REG_D = 3'd3;
    localparam logic [2:0] REG_E = 3'd4;

    // Auto-cycle successor; anything at or past E wraps to A so the index stays in 0..4.
    function automatic logic [2:0] next_reg_idx(input logic [2:0] idx);
        return (idx >= REG_E) ? REG_A : idx + 3'd1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a stable-level counter; pressed pulses on a debounced 0->1.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clock_100mhz,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic pressed
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            pressed_q, pressed_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronised input disagrees with the accepted level.
    always_comb begin
        level_d   = level_q;
        pressed_d = 1'b0;
        cnt_d     = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntMax) begin
                level_d   = sync2_q;
                pressed_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            level_q   <= 1'b0;
            pressed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            pressed_q <= pressed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign level   = level_q;
    assign pressed = pressed_q;

endmodule

// File: rtl/display_scheduler.sv
// Arbitrates the seven-segment display between CPU word requests and the register debug view.
module display_scheduler
    import display_scheduler_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned HOLD_CYCLES     = 200_000_000,
    parameter int unsigned CYCLE_CYCLES    = 100_000_000
) (
    input  logic         clock_100mhz,
    input  logic         reset_n,
    input  logic [159:0] registers,
    input  logic         btn_center,
    input  logic         btn_up,
    input  logic         btn_right,
    input  logic         btn_down,
    input  logic         btn_left,
    input  logic         auto_cycle,
    input  logic         cpu_req,
    input  logic [31:0]  cpu_word,
    input  logic [1:0]   cpu_flash,
    output logic         cpu_ack,
    output logic [31:0]  display_word,
    output logic         flash_upper,
    output logic         flash_lower,
    output logic         source,
    output logic [2:0]   reg_idx
);

    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned CycW  = (CYCLE_CYCLES > 1) ? $clog2(CYCLE_CYCLES) : 1;
    localparam logic [HoldW-1:0] HoldInit = HoldW'(HOLD_CYCLES - 1);
    localparam logic [CycW-1:0]  CycMax   = CycW'(CYCLE_CYCLES - 1);

    logic [NUM_DEBUG_REGS-1:0] btn_raw, btn_level, btn_pressed;
    logic                      unused_btn_level;
    logic                      press_any, accept;
    logic [2:0]                press_idx;

    sched_state_t     state_q;
    logic [2:0]       reg_idx_q;
    logic [HoldW-1:0] hold_q;
    logic [CycW-1:0]  cyc_q;
    logic             ack_q;
    logic [31:0]      word_q;
    logic [1:0]       flash_q;

    logic [31:0]      display_word_q;
    logic             flash_upper_q, flash_lower_q;
    display_source_t  source_q;

    assign btn_raw = {btn_left, btn_down, btn_right, btn_up, btn_center};

    for (genvar i = 0; i < NUM_DEBUG_REGS; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clock_100mhz(clock_100mhz),
            .reset_n     (reset_n),
            .raw         (btn_raw[i]),
            .level       (btn_level[i]),
            .pressed     (btn_pressed[i])
        );
    end

    assign unused_btn_level = ^btn_level;

    always_comb begin
        press_any = |btn_pressed;
        press_idx = REG_A;
        if      (btn_pressed[0]) press_idx = REG_A;
        else if (btn_pressed[1]) press_idx = REG_B;
        else if (btn_pressed[2]) press_idx = REG_C;
        else if (btn_pressed[3]) press_idx = REG_D;
        else if (btn_pressed[4]) press_idx = REG_E;
    end

    // A request still high in the cycle right after its ack is held off for one cycle.
    assign accept = cpu_req & ~ack_q;

    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= DEBUG;
            reg_idx_q <= REG_A;
            hold_q    <= '0;
            cyc_q     <= '0;
            ack_q     <= 1'b0;
            word_q    <= '0;
            flash_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            cyc_q <= '0;
            unique case (state_q)
                DEBUG: begin
                    if (press_any) begin
                        reg_idx_q <= press_idx;
                    end else if (accept) begin
                        state_q <= CPU_HOLD;
                        ack_q   <= 1'b1;
                        word_q  <= cpu_word;
                        flash_q <= cpu_flash;
                        hold_q  <= HoldInit;
                    end else if (auto_cycle) begin
                        if (cyc_q == CycMax) begin
                            reg_idx_q <= next_reg_idx(reg_idx_q);
                        end else begin
                            cyc_q <= cyc_q + 1'b1;
                        end
                    end
                end
                CPU_HOLD: begin
                    if (press_any) begin
                        state_q   <= DEBUG;
                        reg_idx_q <= press_idx;
                    end else if (accept) begin
                        ack_q   <= 1'b1;
                        word_q  <= cpu_word;
                        flash_q <= cpu_flash;
                        hold_q  <= HoldInit;
                    end else if (hold_q == '0) begin
                        state_q <= DEBUG;
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                default: state_q <= DEBUG;
            endcase
        end
    end

    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            display_word_q <= '0;
            flash_upper_q  <= 1'b0;
            flash_lower_q  <= 1'b0;
            source_q       <= SRC_DEBUG;
        end else if (state_q == CPU_HOLD) begin
            display_word_q <= word_q;
            flash_upper_q  <= flash_q[1];
            flash_lower_q  <= flash_q[0];
            source_q       <= SRC_CPU;
        end else begin
            display_word_q <= registers[{reg_idx_q, 5'b0} +: 32];
            flash_upper_q  <= 1'b0;
            flash_lower_q  <= 1'b0;
            source_q       <= SRC_DEBUG;
        end
    end

    assign cpu_ack      = ack_q;
    assign reg_idx      = reg_idx_q;
    assign display_word = display_word_q;
    assign flash_upper  = flash_upper_q;
    assign flash_lower  = flash_lower_q;
    assign source       = source_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with a cycle-level reference model and literal spot checks.
module tb_display_scheduler;

    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int CYC  = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [159:0] registers = '0;
    logic [4:0]   btn = '0;
    logic         auto_cycle = 1'b0;
    logic         cpu_req = 1'b0;
    logic [31:0]  cpu_word = '0;
    logic [1:0]   cpu_flash = '0;
    logic         cpu_ack;
    logic [31:0]  display_word;
    logic         flash_upper, flash_lower, source;
    logic [2:0]   reg_idx;

    int n_vec = 0;
    int n_err = 0;

    display_scheduler #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .CYCLE_CYCLES   (CYC)
    ) dut (
        .clock_100mhz(clk),
        .reset_n     (rst_n),
        .registers   (registers),
        .btn_center  (btn[0]),
        .btn_up      (btn[1]),
        .btn_right   (btn[2]),
        .btn_down    (btn[3]),
        .btn_left    (btn[4]),
        .auto_cycle  (auto_cycle),
        .cpu_req     (cpu_req),
        .cpu_word    (cpu_word),
        .cpu_flash   (cpu_flash),
        .cpu_ack     (cpu_ack),
        .display_word(display_word),
        .flash_upper (flash_upper),
        .flash_lower (flash_lower),
        .source      (source),
        .reg_idx     (reg_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: mode 0 = debug view, 1 = showing a CPU word for hold_left more cycles.
    int       m_hold = 0, m_idx = 0, m_hold_left = 0, m_dwell = 0, m_p = 0;
    bit       m_ack = 0, m_take = 0, m_same = 0;
    bit [31:0] m_word = 0;
    bit [1:0] m_flash = 0;
    bit       m_rd1[5], m_rd2[5], m_level[5], m_press[5];
    bit       m_win[5][DEB];
    bit [31:0] e_word = 0;
    bit       e_fu = 0, e_fl = 0, e_src = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hold = 0; m_idx = 0; m_hold_left = 0; m_dwell = 0; m_ack = 0;
            m_word = 0; m_flash = 0;
            e_word = 0; e_fu = 0; e_fl = 0; e_src = 0;
            for (int b = 0; b < 5; b++) begin
                m_rd1[b] = 0; m_rd2[b] = 0; m_level[b] = 0; m_press[b] = 0;
                for (int k = 0; k < DEB; k++) m_win[b][k] = 0;
            end
        end else begin
            e_src  = (m_hold != 0);
            e_word = (m_hold != 0) ? m_word : registers[m_idx*32 +: 32];
            e_fu   = (m_hold != 0) && m_flash[1];
            e_fl   = (m_hold != 0) && m_flash[0];
            m_p = -1;
            for (int b = 4; b >= 0; b--) if (m_press[b]) m_p = b;
            m_take = cpu_req && !m_ack;
            m_ack  = 0;
            if (m_p >= 0) begin
                m_hold = 0; m_idx = m_p; m_dwell = 0;
            end else if (m_take) begin
                m_hold = 1; m_ack = 1; m_word = cpu_word; m_flash = cpu_flash;
                m_hold_left = HOLD; m_dwell = 0;
            end else if (m_hold != 0) begin
                m_hold_left--;
                if (m_hold_left == 0) m_hold = 0;
            end else if (auto_cycle) begin
                m_dwell++;
                if (m_dwell == CYC) begin
                    m_dwell = 0;
                    m_idx = (m_idx + 1) % 5;
                end
            end else begin
                m_dwell = 0;
            end
            // A level is accepted once the last DEB synchronised samples all disagree with it.
            for (int b = 0; b < 5; b++) begin
                for (int k = 0; k < DEB - 1; k++) m_win[b][k] = m_win[b][k+1];
                m_win[b][DEB-1] = m_rd2[b];
                m_same = 1;
                for (int k = 0; k < DEB; k++) if (m_win[b][k] == m_level[b]) m_same = 0;
                m_press[b] = 0;
                if (m_same) begin
                    m_level[b] = !m_level[b];
                    m_press[b] = m_level[b];
                end
                m_rd2[b] = m_rd1[b];
                m_rd1[b] = btn[b];
            end
        end
    end

    always @(negedge clk) begin
        check("model display_word", display_word, e_word);
        check("model flash_upper", {31'b0, flash_upper}, {31'b0, e_fu});
        check("model flash_lower", {31'b0, flash_lower}, {31'b0, e_fl});
        check("model source", {31'b0, source}, {31'b0, e_src});
        check("model reg_idx", {29'b0, reg_idx}, m_idx[31:0]);
        check("model cpu_ack", {31'b0, cpu_ack}, {31'b0, m_ack});
    end

    initial begin
        registers = {32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        #12;
        check("reset display_word", display_word, 32'h0);
        check("reset source", {31'b0, source}, 32'h0);
        check("reset cpu_ack", {31'b0, cpu_ack}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(1);
        check("post-reset view A", display_word, 32'h11111111);
        check("post-reset reg_idx", {29'b0, reg_idx}, 32'd0);

        // Bounce on btn_up is ignored; a stable hold selects B.
        btn[1] = 1'b1; tick(2); btn[1] = 1'b0; tick(4);
        check("bounce ignored", {29'b0, reg_idx}, 32'd0);
        btn[1] = 1'b1; tick(8);
        check("up selects B", {29'b0, reg_idx}, 32'd1);
        check("view B", display_word, 32'h22222222);
        btn[1] = 1'b0; tick(8);

        // CPU word held for HOLD cycles.
        cpu_word = 32'hDEADBEEF; cpu_flash = 2'b10; cpu_req = 1'b1;
        tick(1);
        check("cpu ack pulse", {31'b0, cpu_ack}, 32'd1);
        cpu_req = 1'b0;
        tick(1);
        check("ack single", {31'b0, cpu_ack}, 32'd0);
        check("cpu word shown", display_word, 32'hDEADBEEF);
        check("flash upper", {31'b0, flash_upper}, 32'd1);
        check("source cpu", {31'b0, source}, 32'd1);
        tick(9);
        check("still holding", {31'b0, source}, 32'd1);
        tick(1);
        check("hold expired", {31'b0, source}, 32'd0);
        check("back to B", display_word, 32'h22222222);

        // btn_left preempts the hold; a concurrent request is acked one cycle later.
        cpu_word = 32'hCAFEF00D; cpu_flash = 2'b01; cpu_req = 1'b1;
        tick(1);
        check("second ack", {31'b0, cpu_ack}, 32'd1);
        cpu_req = 1'b0; btn[4] = 1'b1;
        tick(6);
        cpu_word = 32'h12345678; cpu_flash = 2'b11; cpu_req = 1'b1;
        tick(1);
        check("preempt reg_idx", {29'b0, reg_idx}, 32'd4);
        check("preempt no ack", {31'b0, cpu_ack}, 32'd0);
        tick(1);
        check("deferred ack", {31'b0, cpu_ack}, 32'd1);
        check("view E", display_word, 32'h55555555);
        cpu_req = 1'b0; btn[4] = 1'b0;
        tick(12);

        // Select D, then auto-cycle D -> E -> A, with a btn_right press restarting the dwell.
        btn[3] = 1'b1; tick(8); btn[3] = 1'b0; tick(8);
        check("down selects D", {29'b0, reg_idx}, 32'd3);
        auto_cycle = 1'b1;
        tick(7);
        check("dwell D", {29'b0, reg_idx}, 32'd3);
        tick(1);
        check("auto to E", {29'b0, reg_idx}, 32'd4);
        tick(8);
        check("auto wrap A", {29'b0, reg_idx}, 32'd0);
        tick(2);
        btn[2] = 1'b1;
        tick(6);
        check("auto to B", {29'b0, reg_idx}, 32'd1);
        tick(1);
        check("right selects C", {29'b0, reg_idx}, 32'd2);
        tick(7);
        check("dwell restarted", {29'b0, reg_idx}, 32'd2);
        tick(1);
        check("auto after press", {29'b0, reg_idx}, 32'd3);
        btn[2] = 1'b0; auto_cycle = 1'b0;
        tick(8);
        registers[127:96] = 32'h44440000;
        tick(1);
        check("live register", display_word, 32'h44440000);

        // Reset mid-hold with a request pending.
        cpu_word = 32'h0BADF00D; cpu_flash = 2'b11; cpu_req = 1'b1;
        tick(1);
        check("hold ack", {31'b0, cpu_ack}, 32'd1);
        tick(2);
        #3 rst_n = 1'b0;
        #1;
        check("async reset word", display_word, 32'h0);
        check("async reset source", {31'b0, source}, 32'd0);
        check("async reset flash", {30'b0, flash_upper, flash_lower}, 32'd0);
        check("async reset idx", {29'b0, reg_idx}, 32'd0);
        check("async reset ack", {31'b0, cpu_ack}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(1);
        check("ack after reset", {31'b0, cpu_ack}, 32'd1);
        tick(1);
        check("word after reset", display_word, 32'h0BADF00D);
        check("flash after reset", {30'b0, flash_upper, flash_lower}, 32'd3);
        cpu_req = 1'b0;
        tick(15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Schedules the shared 8-digit seven-segment display (the dword_display instance) between two requesters: the CPU, via a req/ack handshake carrying a word plus flash controls, and the user debug view, which shows one of CPU registers A..E chosen by debounced buttons or by auto-cycling.
- Sits inside peripheral_manager, between the CPU state/control buses and the display driver.
- Replaces the raw, undebounced button-to-index logic.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, cycles a synchronised button level must be stable before it is accepted (10 ms at 100 MHz).
- HOLD_CYCLES, 200_000_000, cycles a CPU word stays on the display after acceptance; must be >= 1.
- CYCLE_CYCLES, 100_000_000, auto-cycle dwell per register; must be >= 1.

Ports:
- clock_100mhz  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- registers  in  160  CPU registers A..E packed as 5 x 32 bits; A is bits [31:0].
- btn_center, btn_up, btn_right, btn_down, btn_left  in  1 each  raw, asynchronous button levels.
- auto_cycle  in  1  switch level; 1 enables auto-cycling in debug view.
- cpu_req  in  1  CPU display request; held until acknowledged.
- cpu_word  in  32  word the CPU wants displayed.
- cpu_flash  in  2  [1] flashes the upper half, [0] flashes the lower half.
- cpu_ack  out  1  one-cycle pulse when the request is accepted.
- display_word  out  32  word sent to dword_display.
- flash_upper, flash_lower  out  1 each  flash controls sent to dword_display.
- source  out  1  0 = debug view, 1 = CPU word.
- reg_idx  out  3  register index currently selected in debug view, 0..4.

Behaviour:
- Reset (asynchronous, reset_n low): display_word=0, flash_upper=0, flash_lower=0, source=0, reg_idx=0, cpu_ack=0. All counters, synchronisers and debouncers clear; the FSM enters DEBUG.
- Button path:
  - Each button passes through a 2-FF synchroniser, then a stable-level counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive cycles of the new synchronised value.
  - A press event is a 0->1 edge of the debounced level.
  - If several press events occur in one cycle, priority is center(0) > up(1) > right(2) > down(3) > left(4).
- FSM states DEBUG and CPU_HOLD:
  - DEBUG to reg_idx: a press event sets reg_idx to the button's index and clears the auto-cycle counter.
  - DEBUG to CPU_HOLD: cpu_req=1 with no press event this cycle. In that cycle: pulse cpu_ack, latch cpu_word and cpu_flash, load the hold counter with HOLD_CYCLES-1.
  - Simultaneous press event and cpu_req in DEBUG: the button wins and cpu_ack stays 0. The request remains pending and is accepted on the next cycle if cpu_req is still 1.
  - CPU_HOLD, new cpu_req: accepted immediately. Pulse cpu_ack, re-latch word and flash, reload the hold counter.
  - CPU_HOLD, hold counter at 0 and no cpu_req: go to DEBUG; reg_idx is unchanged.
  - CPU_HOLD, press event: preempts. Go to DEBUG, set reg_idx, and do not ack any concurrent cpu_req.
  - cpu_ack is never asserted on two consecutive cycles for one request. The CPU drops cpu_req in the cycle after the ack; if cpu_req is still high, it is treated as a new request.
- Auto-cycle:
  - Counts only in DEBUG with auto_cycle=1; cleared otherwise.
  - At CYCLE_CYCLES-1 it wraps to 0 and reg_idx advances, 4 wraps to 0.
  - A press event in the same cycle overrides the advance.
- Outputs (registered, 1-cycle latency from FSM state and inputs):
  - DEBUG: display_word = registers[reg_idx], tracking live register values every cycle; flash_upper=0, flash_lower=0, source=0.
  - CPU_HOLD: display_word = latched word; flash_upper/flash_lower = latched cpu_flash; source=1.
- Widths: counters are sized by $clog2 of their parameter. reg_idx is never outside 0..4.
- Reset asserted mid-hold or mid-debounce aborts immediately. No ack is issued for a request pending at reset.

Decomposition:
- peripherals package gains:
  - display_source_t enum: SRC_DEBUG=1'b0, SRC_CPU=1'b1.
  - sched_state_t enum: DEBUG, CPU_HOLD.
  - localparam NUM_DEBUG_REGS=5.
  - register index constants REG_A..REG_E = 0..4.
- Sub-module button_debouncer (parameter DEBOUNCE_CYCLES; ports clock_100mhz, reset_n, raw, level, pressed), instantiated 5 times.
- The FSM, hold counter, auto-cycle counter and output mux live in display_scheduler.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, CYCLE_CYCLES=8):
- Reset, then registers A=0x11111111 .. E=0x55555555, no input -> display_word=0x11111111, source=0, reg_idx=0 one cycle after reset release.
- btn_up pulsed for 2 cycles (bounce), then held for 8 cycles -> no change from the pulse. reg_idx=1 and display_word=0x22222222 about 2+4+1 cycles after the stable hold begins.
- cpu_req with cpu_word=0xDEADBEEF, cpu_flash=2'b10 -> exactly one cpu_ack pulse; next cycle display_word=0xDEADBEEF, flash_upper=1, source=1. Exactly 10 cycles after the ack, the view returns to registers[reg_idx] with source=0.
- In CPU_HOLD, a debounced btn_left press -> immediate return to DEBUG, reg_idx=4, display_word=0x55555555. A second cpu_req asserted on the same cycle gets no ack that cycle and is acked the following cycle.
- auto_cycle=1 with reg_idx=3 -> reg_idx goes 4 then 0 at 8-cycle intervals. A btn_right press mid-dwell sets reg_idx=2 and restarts the 8-cycle dwell.
- reset_n pulsed low during CPU_HOLD with cpu_req high -> all outputs 0 asynchronously; after release, the pending request is acked one cycle later.
